// File: rtl/huffman_stream_packer.sv
// rtl/huffman_stream_packer.sv - table-driven Huffman symbol lookup and MSB-first packing into fixed-width words
module huffman_stream_packer #(
   parameter int SYM_W   = 8,
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int OUT_W   = 16,
   parameter int NB_W    = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tbl_we,
   input  logic [SYM_W-1:0]   tbl_addr,
   input  logic [MAX_LEN-1:0] tbl_code,
   input  logic [LEN_W-1:0]   tbl_len,
   input  logic [SYM_W-1:0]   data_in,
   input  logic               data_enable,
   output logic               data_ready,
   input  logic               flush,
   output logic [OUT_W-1:0]   data_out,
   output logic               data_out_valid,
   input  logic               data_out_ready,
   output logic               data_out_last,
   output logic [NB_W-1:0]    data_out_nbits,
   output logic [1:0]         out_state,
   output logic               len_err,
   output logic [31:0]        sym_count
);

   localparam int ACC_W  = OUT_W + MAX_LEN;
   localparam int FILL_W = $clog2(ACC_W + 1);
   localparam int DEPTH  = 1 << SYM_W;

   localparam logic [FILL_W-1:0] OUT_W_F   = FILL_W'(OUT_W);
   localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [NB_W-1:0]   OUT_W_NB  = NB_W'(OUT_W);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_FLUSH_WAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH_LAST = 2'd2;

   logic [MAX_LEN-1:0] code_mem [0:DEPTH-1];
   logic [LEN_W-1:0]   len_mem  [0:DEPTH-1];

   logic               lk_valid;
   logic [MAX_LEN-1:0] lk_code;
   logic [LEN_W-1:0]   lk_len;

   // acc holds fill stream bits left-aligned at the MSB; everything below fill is zero
   logic [ACC_W-1:0]   acc;
   logic [FILL_W-1:0]  fill;
   logic [1:0]         state;

   logic               out_free;
   logic               do_move;
   logic               do_merge;
   logic               do_last;
   logic               accept;
   logic               len_bad;
   logic [LEN_W-1:0]   len_eff;
   logic [MAX_LEN-1:0] code_mask;
   logic [ACC_W-1:0]   code_al;
   logic [ACC_W-1:0]   acc_m;
   logic [ACC_W-1:0]   acc_n;
   logic [FILL_W-1:0]  fill_m;
   logic [FILL_W-1:0]  fill_n;

   assign out_state = state;

   // move-then-merge datapath and input handshake
   always_comb begin
      out_free  = !data_out_valid || data_out_ready;
      do_move   = (fill >= OUT_W_F) && out_free;
      fill_m    = do_move ? (fill - OUT_W_F) : fill;
      acc_m     = do_move ? (acc << OUT_W) : acc;
      do_merge  = lk_valid && (fill_m < OUT_W_F);
      len_bad   = (lk_len == '0) || (lk_len > MAX_LEN_L);
      len_eff   = (lk_len > MAX_LEN_L) ? MAX_LEN_L : lk_len;
      code_mask = {MAX_LEN{1'b1}} >> (MAX_LEN_L - len_eff);
      code_al   = {lk_code & code_mask, {OUT_W{1'b0}}} << (MAX_LEN_L - len_eff);
      acc_n     = do_merge ? (acc_m | (code_al >> fill_m)) : acc_m;
      fill_n    = do_merge ? (fill_m + FILL_W'(len_eff)) : fill_m;
      do_last   = (state == ST_FLUSH_LAST) && out_free;
      data_ready = !reset && (state == ST_RUN) && (!lk_valid || do_merge);
      accept    = data_enable && data_ready;
   end

   // code table, never reset; a write is seen by lookups from the following edge
   always_ff @(posedge clock) begin
      if (tbl_we) begin
         code_mem[tbl_addr] <= tbl_code;
         len_mem[tbl_addr]  <= tbl_len;
      end
   end

   // lookup stage, accumulator, output register, counters and flush FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         lk_valid       <= 1'b0;
         lk_code        <= '0;
         lk_len         <= '0;
         acc            <= '0;
         fill           <= '0;
         state          <= ST_RUN;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
         data_out_nbits <= '0;
         len_err        <= 1'b0;
         sym_count      <= '0;
      end else begin
         if (accept) begin
            lk_valid <= 1'b1;
            lk_code  <= code_mem[data_in];
            lk_len   <= len_mem[data_in];
         end else if (do_merge) begin
            lk_valid <= 1'b0;
         end

         if (do_last) begin
            acc  <= '0;
            fill <= '0;
         end else begin
            acc  <= acc_n;
            fill <= fill_n;
         end

         if (do_move) begin
            data_out       <= acc[ACC_W-1 -: OUT_W];
            data_out_valid <= 1'b1;
            data_out_nbits <= OUT_W_NB;
            data_out_last  <= 1'b0;
         end else if (do_last) begin
            data_out       <= acc[ACC_W-1 -: OUT_W];
            data_out_valid <= 1'b1;
            data_out_nbits <= NB_W'(fill);
            data_out_last  <= 1'b1;
         end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
         end

         if (do_merge && len_bad)
            len_err <= 1'b1;

         if (accept)
            sym_count <= sym_count + 32'd1;

         case (state)
            ST_RUN: begin
               if (flush)
                  state <= ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
               if (!lk_valid && (fill < OUT_W_F))
                  state <= ST_FLUSH_LAST;
            end
            ST_FLUSH_LAST: begin
               if (out_free)
                  state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: doc/huffman_stream_packer.md
Name: huffman_stream_packer

Overview:
Parametrised successor to the fixed-width Huffman encoder. It takes a stream of symbols, looks up each code and length in a run-time-loadable table, and packs the variable-length codes MSB-first into fixed OUT_W-bit words. Both sides use valid/ready handshakes, and an explicit flush emits a final padded word. It sits between the symbol source and the compressed-stream writer.

Parameters:
SYM_W, 8, symbol width; table depth is 2**SYM_W
MAX_LEN, 8, maximum code length in bits; code field width
LEN_W, 4, width of the length field; must satisfy 2**LEN_W > MAX_LEN
OUT_W, 16, packed output word width; must satisfy OUT_W >= MAX_LEN
NB_W, 5, width of data_out_nbits; must satisfy 2**NB_W > OUT_W

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
tbl_we  in  1  table write strobe
tbl_addr  in  SYM_W  symbol whose entry is written
tbl_code  in  MAX_LEN  code, right-justified
tbl_len  in  LEN_W  code length
data_in  in  SYM_W  input symbol
data_enable  in  1  input valid
data_ready  out  1  input ready
flush  in  1  end-of-block request (single-cycle pulse)
data_out  out  OUT_W  packed word, first stream bit at MSB
data_out_valid  out  1  output valid
data_out_ready  in  1  output ready
data_out_last  out  1  marks the final word of a flush
data_out_nbits  out  NB_W  number of meaningful bits in data_out
out_state  out  2  0=RUN, 1=FLUSH_WAIT, 2=FLUSH_LAST
len_err  out  1  sticky; a symbol was looked up with len 0 or len > MAX_LEN
sym_count  out  32  count of accepted symbols; wraps at 2**32

Behaviour:
- Reset, synchronous: all outputs 0, fill=0, lookup stage empty, out_state=RUN.
  - data_ready is forced 0 during reset and reads 1 on the first cycle after reset.
  - Table contents are not cleared. Partial bits are discarded; no last word is emitted.
- Table write: a write at edge k is visible to lookups from edge k+1.
  - A symbol accepted on the same edge as a write to its own address uses the old entry.
- Pipeline:
  - Stage L: the symbol is accepted when data_enable && data_ready. The table is read synchronously into lk_code/lk_len with lk_valid=1.
  - Accumulator: acc is OUT_W+MAX_LEN bits wide; fill ranges 0..OUT_W+MAX_LEN-1.
  - Output register: holds the word presented on data_out.
- Per cycle, first the move step:
  - If fill >= OUT_W and the output register is free (!data_out_valid || data_out_ready), load the top OUT_W bits into data_out.
  - Set data_out_valid=1, nbits=OUT_W, last=0; fill -= OUT_W.
- Then the merge step:
  - If lk_valid and fill-after-move < OUT_W, append the low lk_len bits of lk_code MSB-first; fill += lk_len.
- data_ready = (out_state==RUN) && (!lk_valid || merge_this_cycle). Throughput is 1 symbol per cycle while the output drains.
- Latency: a symbol accepted at edge k merges at k+1. If it completes a word, data_out_valid is seen after edge k+2.
- Length errors:
  - len 0 contributes no bits.
  - len > MAX_LEN is treated as MAX_LEN.
  - Both cases set len_err (sticky until reset). The symbol is still counted.
- Output hold: data_out, nbits and last stay stable while valid && !ready.
- FSM:
  - RUN -> FLUSH_WAIT on flush=1. A flush coinciding with an accepted symbol includes that symbol.
  - FLUSH_WAIT: input blocked; full words keep draining. Move to FLUSH_LAST when lk empty and fill < OUT_W.
  - FLUSH_LAST: when the output register is free, emit the remaining fill bits left-aligned and zero-padded, with nbits=fill, last=1, fill=0, then go to RUN.
    - If fill==0, emit data_out=0, nbits=0, last=1.
- flush while not in RUN is ignored.
- sym_count increments on each accepted symbol; it is cleared only by reset.

Test Plan:
1. Load table 0x41 'A' = code 2'b10 / len 2 and 0x42 'B' = code 3'b110 / len 3; send ABABABAB with data_out_ready=1, then flush. Expect:
   - word 0xB5AD, nbits=16, last=0;
   - then 0x6000, nbits=4, last=1;
   - sym_count=8, out_state back to 0.
2. Reset, then flush with no symbols -> single word 0x0000, nbits=0, last=1.
3. All entries len 8; hold data_out_ready=0; assert data_enable continuously. Expect:
   - exactly 5 symbols accepted, then data_ready=0 with data_out stable;
   - after releasing ready, all 40 bits appear in order with no loss.
4. Symbol with len 0 between two 'A's, then flush -> last word 0xA000, nbits=4, len_err=1, sym_count=3.
5. Table write to 0x41 on the same edge 'A' is accepted -> that 'A' uses the old code; the next 'A' uses the new code.
6. Assert reset mid-stream with fill=11 and data_out_valid=1. Expect:
   - next cycle all outputs 0, no last word;
   - a subsequent ABABABAB + flush reproduces scenario 1 exactly.
